fifo_ctrl: RTL and testbench

Pointer and flag controller that sequences the dual-address `Ram` block as a first-word-fall-through FIFO. It accepts push/pop requests, drives the RAM's active-low write/read enables, `valid_write` and both address buses, and keeps full/empty/almost-full flags, occupancy and sticky error flags. Data never passes through this block: write data goes straight into the RAM, and the RAM's combinational read port supplies the head word.

---
 rtl/fifo_ctrl.sv | 88 ++++++++
 tb/tb_fifo_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller that runs a dual-address RAM as a first-word-fall-through FIFO.
// Data never passes through here: the RAM takes write data directly and its combinational read
// port supplies the head word addressed by rd_adb.
module fifo_ctrl #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 2**DEPTH - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  output logic             wr_ena,
  output logic             valid_write,
  output logic             rd_ena,
  output logic [DEPTH-1:0] wr_adb,
  output logic [DEPTH-1:0] rd_adb,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [DEPTH:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [DEPTH:0] One     = (DEPTH+1)'(1);
  localparam logic [DEPTH:0] AfLevel = (DEPTH+1)'(AF_LEVEL);

  // Pointers carry an extra wrap bit so full and empty can be told apart.
  logic [DEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0] count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;
  logic           push_ok, pop_ok;

  // Flags, addresses and request acceptance from the registered state.
  always_comb begin
    wr_adb      = wr_ptr_q[DEPTH-1:0];
    rd_adb      = rd_ptr_q[DEPTH-1:0];
    empty       = (wr_ptr_q == rd_ptr_q);
    full        = (wr_ptr_q[DEPTH-1:0] == rd_ptr_q[DEPTH-1:0]) &&
                  (wr_ptr_q[DEPTH] != rd_ptr_q[DEPTH]);
    almost_full = (count_q >= AfLevel);
    count       = count_q;
    overflow    = overflow_q;
    underflow   = underflow_q;
    // A push while full is still safe if a pop vacates the head slot in the same edge.
    push_ok     = push && (!full || pop) && !rst;
    pop_ok      = pop && !empty && !rst;
    valid_write = push_ok;
    wr_ena      = !push_ok;
    rd_ena      = empty;
  end

  // Next-state: pointer advance, occupancy and sticky error capture.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (push && !push_ok);
    underflow_d = underflow_q | (pop && !pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + One;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + One;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + One;
      2'b01:   count_d = count_q - One;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset; RAM contents are left untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with DEPTH=2, AF_LEVEL=3 and a small behavioural RAM.
module tb_fifo_ctrl;

  localparam int unsigned DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst, push, pop;
  logic             wr_ena, valid_write, rd_ena;
  logic [DEPTH-1:0] wr_adb, rd_adb;
  logic             full, empty, almost_full, overflow, underflow;
  logic [DEPTH:0]   count;
  logic [7:0]       wr_data;
  logic [7:0]       rd_data;
  logic [7:0]       mem [4];
  logic [7:0]       vals [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.DEPTH(DEPTH), .AF_LEVEL(3)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .wr_ena(wr_ena), .valid_write(valid_write), .rd_ena(rd_ena),
    .wr_adb(wr_adb), .rd_adb(rd_adb),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // RAM model: write on the edge when enabled, combinational read.
  always @(posedge clk) if (!wr_ena && valid_write) mem[wr_adb] <= wr_data;
  assign rd_data = mem[rd_adb];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    push = 1'b1; wr_data = d;
    step();
    push = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; push = 1'b0; pop = 1'b0; wr_data = 8'h00;
    step(); step();
    rst = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b exp 0", almost_full); end
    checks++; if (rd_ena !== 1'b1) begin errors++; $display("FAIL reset_rd_ena: got %b exp 1", rd_ena); end
    checks++; if (wr_adb !== 2'd0 || rd_adb !== 2'd0) begin
      errors++; $display("FAIL reset_addr: got wr %0d rd %0d exp 0 0", wr_adb, rd_adb); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL reset_err: got ovf %b unf %b exp 0 0", overflow, underflow); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      logic exp_af;
      exp_af = (i >= 2);
      push = 1'b1; wr_data = vals[i];
      #1;
      checks++; if (wr_ena !== 1'b0 || valid_write !== 1'b1) begin
        errors++; $display("FAIL fill_wen[%0d]: got wr_ena %b vw %b exp 0 1", i, wr_ena, valid_write); end
      checks++; if (wr_adb !== 2'(i)) begin
        errors++; $display("FAIL fill_wr_adb[%0d]: got %0d exp %0d", i, wr_adb, i); end
      step();
      push = 1'b0;
      checks++; if (count !== 3'(i + 1)) begin
        errors++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, count, i + 1); end
      checks++; if (almost_full !== exp_af) begin
        errors++; $display("FAIL fill_af[%0d]: got %b exp %b", i, almost_full, exp_af); end
      checks++; if (full !== (i == 3)) begin
        errors++; $display("FAIL fill_full[%0d]: got %b exp %b", i, full, i == 3); end
    end
  endtask

  task automatic test_overflow();
    push = 1'b1; wr_data = 8'hE0;
    #1;
    checks++; if (wr_ena !== 1'b1 || valid_write !== 1'b0) begin
      errors++; $display("FAIL ovf_wen: got wr_ena %b vw %b exp 1 0", wr_ena, valid_write); end
    step();
    push = 1'b0;
    checks++; if (count !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: got count %0d ovf %b exp 4 1", count, overflow); end
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      #1;
      checks++; if (rd_ena !== 1'b0 || rd_data !== vals[i]) begin
        errors++; $display("FAIL ovf_drain[%0d]: got rd_ena %b data %h exp 0 %h", i, rd_ena, rd_data, vals[i]); end
      step();
    end
    pop = 1'b0;
    checks++; if (empty !== 1'b1 || rd_ena !== 1'b1 || count !== 3'd0) begin
      errors++; $display("FAIL ovf_empty: got empty %b rd_ena %b count %0d exp 1 1 0", empty, rd_ena, count); end
  endtask

  task automatic test_underflow();
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++; if (underflow !== 1'b1 || rd_adb !== 2'd0 || count !== 3'd0) begin
      errors++; $display("FAIL unf_flag: got unf %b rd_adb %0d count %0d exp 1 0 0", underflow, rd_adb, count); end
    push = 1'b1; pop = 1'b1; wr_data = 8'h5A;
    #1;
    checks++; if (wr_ena !== 1'b0) begin errors++; $display("FAIL unf_push_ok: got wr_ena %b exp 0", wr_ena); end
    step();
    push = 1'b0; pop = 1'b0;
    checks++; if (underflow !== 1'b1 || count !== 3'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL unf_both: got unf %b count %0d empty %b exp 1 1 0", underflow, count, empty); end
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL unf_data: got %h exp 5a", rd_data); end
  endtask

  task automatic test_push_pop_full();
    test_reset();
    test_fill();
    push = 1'b1; pop = 1'b1; wr_data = 8'hF0;
    #1;
    checks++; if (rd_data !== vals[0] || wr_ena !== 1'b0 || wr_adb !== 2'd0) begin
      errors++; $display("FAIL ppf_comb: got data %h wr_ena %b wr_adb %0d exp %h 0 0", rd_data, wr_ena, wr_adb, vals[0]); end
    step();
    push = 1'b0; pop = 1'b0;
    checks++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL ppf_state: got count %0d full %b ovf %b exp 4 1 0", count, full, overflow); end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_d;
      exp_d = (i == 3) ? 8'hF0 : vals[i + 1];
      pop = 1'b1;
      #1;
      checks++; if (rd_data !== exp_d) begin
        errors++; $display("FAIL ppf_drain[%0d]: got %h exp %h", i, rd_data, exp_d); end
      step();
    end
    pop = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ppf_empty: got %b exp 1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ra;
    exp_ra = 2'd1;  // rd_ptr sits at address 1 after the previous scenario
    push_word(8'h30);
    for (int i = 0; i < 10; i++) begin
      push = 1'b1; pop = 1'b1; wr_data = 8'h31 + 8'(i);
      #1;
      checks++; if (rd_data !== 8'h30 + 8'(i) || rd_adb !== exp_ra) begin
        errors++; $display("FAIL b2b_read[%0d]: got data %h rd_adb %0d exp %h %0d", i, rd_data, rd_adb, 8'h30 + 8'(i), exp_ra); end
      step();
      exp_ra = exp_ra + 2'd1;
      checks++; if (count !== 3'd1 || empty !== 1'b0 || full !== 1'b0 || almost_full !== 1'b0) begin
        errors++; $display("FAIL b2b_flags[%0d]: got count %0d e %b f %b af %b exp 1 0 0 0", i, count, empty, full, almost_full); end
    end
    push = 1'b0;
    #1;
    checks++; if (rd_data !== 8'h3A) begin errors++; $display("FAIL b2b_last: got %h exp 3a", rd_data); end
    step();
    pop = 1'b0;
    checks++; if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got e %b ovf %b unf %b exp 1 0 0", empty, overflow, underflow); end
  endtask

  task automatic test_reset_mid();
    pop = 1'b1;
    step();
    pop = 1'b0;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    checks++; if (count !== 3'd3 || underflow !== 1'b1) begin
      errors++; $display("FAIL rmid_pre: got count %0d unf %b exp 3 1", count, underflow); end
    rst = 1'b1; push = 1'b1; wr_data = 8'h44;
    #1;
    checks++; if (wr_ena !== 1'b1 || valid_write !== 1'b0) begin
      errors++; $display("FAIL rmid_wen: got wr_ena %b vw %b exp 1 0", wr_ena, valid_write); end
    step();
    rst = 1'b0; push = 1'b0;
    checks++; if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL rmid_state: got count %0d e %b ovf %b unf %b exp 0 1 0 0", count, empty, overflow, underflow); end
    checks++; if (wr_adb !== 2'd0 || rd_adb !== 2'd0) begin
      errors++; $display("FAIL rmid_addr: got wr %0d rd %0d exp 0 0", wr_adb, rd_adb); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vals[0] = 8'hA0; vals[1] = 8'hB0; vals[2] = 8'hC0; vals[3] = 8'hD0;
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_push_pop_full();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
